cbuf_addr_ctrl: RTL and testbench
=================================

# cbuf_addr_ctrl

Circular-buffer address controller for the ADC path in circular-buffer (CBUF) acquisition mode. It advances the write pointer as packed ADC words enter the circular buffer. On each accepted trigger it computes the pre-trigger start address and queues it in a first-word-fall-through (FWFT) trigger-address FIFO. It also owns the read pointer that `adc_acq_sm_cbuf` drives through `init_circ_buf_rd_addr` and `inc_circ_buf_rd_addr`. It sits directly upstream of the acquisition state machine and feeds that machine's `trig_fifo_empty` input.

## Interface
Parameters:
- ADDR_W, 12, circular-buffer address width (depth 2^ADDR_W 32-bit words)
- FIFO_AW, 3, trigger-FIFO address width (depth 2^FIFO_AW = 8)
- CNT_W, 8, width of the saturating drop counter

Ports:
- clk  in  1  ADC clock domain (400 MHz)
- reset_n  in  1  asynchronous, active-low reset
- cbuf_wr_en  in  1  one 32-bit word is written to the circular buffer this cycle
- acq_armed  in  1  acquisition mode enabled (already synchronous to clk)
- trig_pulse  in  1  single-cycle trigger, synchronous to clk
- pretrig_len  in  ADDR_W  number of words saved before the trigger; quasi-static while armed
- trig_addr_rd_en  in  1  pop the FIFO head
- init_circ_buf_rd_addr  in  1  load the read pointer from the FIFO head
- inc_circ_buf_rd_addr  in  1  advance the read pointer
- cbuf_wr_addr  out  ADDR_W  current write address
- cbuf_rd_addr  out  ADDR_W  current read address
- trig_addr  out  ADDR_W  FWFT head of the trigger FIFO
- trig_fifo_empty  out  1  trigger FIFO empty
- trig_fifo_full  out  1  trigger FIFO full
- trig_drop_cnt  out  CNT_W  saturating count of triggers rejected since arming
- cbuf_ready  out  1  arm state machine is in READY

## Operation
- Write pointer:
  - `cbuf_wr_addr` increments by 1 modulo 2^ADDR_W on each `cbuf_wr_en`.
  - It free-runs regardless of arm state; it is cleared only by reset.
- Arm state machine, states DISARMED, WARMUP, READY:
  - DISARMED -> WARMUP when `acq_armed`=1. Entering WARMUP flushes the FIFO, clears `trig_drop_cnt` and clears `fill_cnt`.
  - In WARMUP, `fill_cnt` increments on each `cbuf_wr_en`, saturating at 2^ADDR_W-1.
  - WARMUP -> READY when `fill_cnt` >= `pretrig_len`. With `pretrig_len`=0 this transition happens on the first cycle in WARMUP.
  - Any state -> DISARMED when `acq_armed`=0. The FIFO is not flushed on disarm, so an in-progress readout completes.
- Trigger acceptance requires `trig_pulse`=1, state READY, and FIFO not full OR a pop in the same cycle.
  - Pushed value = (`cbuf_wr_addr` as sampled in the trigger cycle − `pretrig_len`) mod 2^ADDR_W. This is the pre-increment address even if `cbuf_wr_en` is also high.
  - Wrap-around uses natural ADDR_W-bit subtraction.
- Rejection:
  - A trigger in WARMUP, or in READY with the FIFO full and no pop, is dropped.
  - A dropped trigger increments `trig_drop_cnt`, which saturates at all-ones.
  - A trigger in DISARMED is ignored and not counted.
- FIFO:
  - Depth 2^FIFO_AW, FWFT: `trig_addr` is valid whenever `trig_fifo_empty`=0.
  - A pop while empty is ignored.
  - Simultaneous push and pop when count=0: the pop is ignored and the push is accepted.
  - Simultaneous push and pop when count=DEPTH: both take effect and the count is unchanged.
- Read pointer:
  - `init_circ_buf_rd_addr` loads `trig_addr`, the head value in that same cycle, before any same-cycle pop takes effect.
  - `inc_circ_buf_rd_addr` increments modulo 2^ADDR_W.
  - If init and inc are both high, init has priority.
  - Init while the FIFO is empty loads the stale head register; this is a protocol error and is not checked.

## Timing
- Reset values: `cbuf_wr_addr`=0, `cbuf_rd_addr`=0, `trig_addr`=0, `trig_fifo_empty`=1, `trig_fifo_full`=0, `trig_drop_cnt`=0, `cbuf_ready`=0, state DISARMED, `fill_cnt`=0.
- `acq_armed` rising at cycle N: state is WARMUP at N+1 and the flush is complete at N+1.
- Accepted trigger at cycle N: `trig_fifo_empty`=0 and `trig_addr` valid at N+1.
- Pop at cycle N: the next head (or `trig_fifo_empty`=1) is visible at N+1.
- Init or inc at cycle N: the new `cbuf_rd_addr` is visible at N+1.
- All outputs are registered. No combinational path exists from inputs to outputs.
- `reset_n` asserted mid-operation: all state returns to reset values immediately (asynchronously). Deassertion is synchronised externally.

## Structure
- Shared package `cbuf_pkg`: ADDR_W/FIFO_AW defaults and the arm-state encoding (DISARMED=0, WARMUP=1, READY=2).
- Sub-module `cbuf_trig_fifo`: parameterised FWFT FIFO with push, pop, head, empty, full and count, and a synchronous flush.
- Arm state machine, pointers and drop counter live in the top level.

## Test plan
- Arm with `pretrig_len`=256 and `cbuf_wr_en` held high; trigger when `cbuf_wr_addr`=300 -> `trig_addr`=44 one cycle later, `trig_fifo_empty`=0.
- Wrap: trigger at `cbuf_wr_addr`=100 with `pretrig_len`=256 -> `trig_addr`=3940 (0xF64).
- Warm-up: arm, trigger after 100 writes with `pretrig_len`=256 -> no push and `trig_drop_cnt`=1; after the 256th write `cbuf_ready`=1 and the next trigger is pushed.
- Full FIFO: 9 triggers with no pops -> 8 entries, `trig_fifo_full`=1, `trig_drop_cnt`=1. Trigger plus pop in the same cycle when full -> count stays 8 and the new address is at the tail.
- Readout: head=44, assert init and `trig_addr_rd_en` together -> `cbuf_rd_addr`=44 next cycle and the head advances. Then 4 inc pulses -> 48. Also inc from 4095 -> 0.
- Reset mid-operation: with 3 entries queued and `cbuf_rd_addr`=500, drop `reset_n` -> all outputs at reset values immediately and `trig_fifo_empty`=1.

Source files
------------

// File: rtl/cbuf_pkg.sv
// Shared definitions for the circular-buffer address controller.
//   - Default address widths for the circular buffer and the trigger FIFO.
//   - Arm state encoding used by cbuf_addr_ctrl.
package cbuf_pkg;

    localparam int CBUF_ADDR_W  = 12;
    localparam int CBUF_FIFO_AW = 3;
    localparam int CBUF_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_READY    = 2'd2
    } arm_state_e;

endpackage : cbuf_pkg

// File: rtl/cbuf_trig_fifo.sv
// First-word-fall-through FIFO holding pre-trigger start addresses.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous clear of all entries (has priority over push/pop)
//   push, push_data : enqueue one entry (ignored when full unless popping too)
//   pop          : dequeue head (ignored when empty)
//   head         : registered head value, valid whenever empty = 0
//   empty, full  : registered status flags
//   count        : number of stored entries (0 .. 2^AW)
module cbuf_trig_fifo #(
    parameter int W  = 12,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [W-1:0]  head_r;
    logic          empty_r;
    logic          full_r;

    logic          pop_eff_s;
    logic          push_eff_s;
    logic [AW:0]   count_nxt_s;
    logic [AW-1:0] rd_next_s;
    logic [W-1:0]  head_nxt_s;

    // Effective push/pop qualification, next count and next head value.
    always_comb begin
        pop_eff_s   = 1'b0;
        push_eff_s  = 1'b0;
        count_nxt_s = count_r;
        rd_next_s   = rd_ptr_r + PTR_ONE;
        head_nxt_s  = head_r;

        if (flush) begin
            pop_eff_s  = 1'b0;
            push_eff_s = 1'b0;
        end else begin
            pop_eff_s  = pop && !empty_r;
            // A push into a full FIFO only fits when the head leaves this cycle.
            push_eff_s = push && (!full_r || pop_eff_s);
        end

        if (push_eff_s && !pop_eff_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_eff_s && !push_eff_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end

        // The head register is preloaded so the output needs no read mux.
        // When the FIFO drains, the last head value is kept (stale).
        if (pop_eff_s && (count_r > CNT_ONE)) begin
            head_nxt_s = mem_r[rd_next_s];
        end else if (push_eff_s && ((count_r == '0) || (pop_eff_s && (count_r == CNT_ONE)))) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Storage array; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_eff_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy, flags and head register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (push_eff_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_eff_s) begin
                rd_ptr_r <= rd_next_s;
            end
            count_r <= count_nxt_s;
            head_r  <= head_nxt_s;
            empty_r <= (count_nxt_s == '0);
            full_r  <= (count_nxt_s == DEPTH_C);
        end
    end

    assign head  = head_r;
    assign empty = empty_r;
    assign full  = full_r;
    assign count = count_r;

endmodule : cbuf_trig_fifo

// File: rtl/cbuf_addr_ctrl.sv
// Circular-buffer address controller for CBUF acquisition mode.
//   clk, reset_n          : ADC clock, asynchronous active-low reset
//   cbuf_wr_en            : one word written to the circular buffer this cycle
//   acq_armed             : acquisition enabled
//   trig_pulse            : single-cycle trigger
//   pretrig_len           : words kept before the trigger (quasi-static while armed)
//   trig_addr_rd_en       : pop trigger FIFO head
//   init_circ_buf_rd_addr : load read pointer from FIFO head
//   inc_circ_buf_rd_addr  : advance read pointer
//   cbuf_wr_addr / cbuf_rd_addr : write / read pointers
//   trig_addr, trig_fifo_empty, trig_fifo_full : trigger FIFO head and status
//   trig_drop_cnt         : saturating count of rejected triggers since arming
//   cbuf_ready            : arm state machine is READY
module cbuf_addr_ctrl
    import cbuf_pkg::*;
#(
    parameter int ADDR_W  = CBUF_ADDR_W,
    parameter int FIFO_AW = CBUF_FIFO_AW,
    parameter int CNT_W   = CBUF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cbuf_wr_en,
    input  logic              acq_armed,
    input  logic              trig_pulse,
    input  logic [ADDR_W-1:0] pretrig_len,
    input  logic              trig_addr_rd_en,
    input  logic              init_circ_buf_rd_addr,
    input  logic              inc_circ_buf_rd_addr,
    output logic [ADDR_W-1:0] cbuf_wr_addr,
    output logic [ADDR_W-1:0] cbuf_rd_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              trig_fifo_empty,
    output logic              trig_fifo_full,
    output logic [CNT_W-1:0]  trig_drop_cnt,
    output logic              cbuf_ready
);

    localparam int             DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // Start of the pre-trigger window; natural ADDR_W-bit wrap.
    function automatic logic [ADDR_W-1:0] pretrig_start(
        input logic [ADDR_W-1:0] wr_addr,
        input logic [ADDR_W-1:0] len
    );
        return wr_addr - len;
    endfunction

    arm_state_e          state_r;
    arm_state_e          state_nxt_s;
    logic                arm_entry_s;
    logic                ready_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic [ADDR_W-1:0]   fill_cnt_r;
    logic [CNT_W-1:0]    drop_cnt_r;

    logic                accept_s;
    logic                drop_s;
    logic [ADDR_W-1:0]   push_addr_s;
    logic [ADDR_W-1:0]   fifo_head_s;
    logic                fifo_empty_s;
    logic                fifo_full_s;
    logic [FIFO_AW:0]    fifo_count_s;

    // Arm state machine next-state logic; arm_entry_s marks the DISARMED->WARMUP step.
    always_comb begin
        state_nxt_s = state_r;
        arm_entry_s = 1'b0;
        case (state_r)
            ST_DISARMED: begin
                if (acq_armed) begin
                    state_nxt_s = ST_WARMUP;
                    arm_entry_s = 1'b1;
                end else begin
                    state_nxt_s = ST_DISARMED;
                end
            end
            ST_WARMUP: begin
                if (!acq_armed) begin
                    state_nxt_s = ST_DISARMED;
                end else if (fill_cnt_r >= pretrig_len) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_WARMUP;
                end
            end
            ST_READY: begin
                if (!acq_armed) begin
                    state_nxt_s = ST_DISARMED;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            default: begin
                state_nxt_s = ST_DISARMED;
            end
        endcase
    end

    // Trigger accept/drop decision; a same-cycle pop makes room in a full FIFO.
    always_comb begin
        accept_s    = 1'b0;
        drop_s      = 1'b0;
        push_addr_s = pretrig_start(wr_addr_r, pretrig_len);
        if (trig_pulse && (state_r == ST_READY)) begin
            accept_s = (fifo_count_s != DEPTH_C) || trig_addr_rd_en;
            drop_s   = !accept_s;
        end else if (trig_pulse && (state_r == ST_WARMUP)) begin
            accept_s = 1'b0;
            drop_s   = 1'b1;
        end else begin
            accept_s = 1'b0;
            drop_s   = 1'b0;
        end
    end

    // Arm state register and registered READY flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_DISARMED;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_READY);
        end
    end

    // Free-running write pointer, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_addr_r <= '0;
        end else if (cbuf_wr_en) begin
            wr_addr_r <= wr_addr_r + ADDR_ONE;
        end
    end

    // Warm-up fill counter: words written since arming, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_cnt_r <= '0;
        end else if (arm_entry_s) begin
            fill_cnt_r <= '0;
        end else if ((state_r == ST_WARMUP) && cbuf_wr_en && (fill_cnt_r != '1)) begin
            fill_cnt_r <= fill_cnt_r + ADDR_ONE;
        end
    end

    // Saturating dropped-trigger counter, cleared on arming.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_r <= '0;
        end else if (arm_entry_s) begin
            drop_cnt_r <= '0;
        end else if (drop_s && (drop_cnt_r != '1)) begin
            drop_cnt_r <= drop_cnt_r + CNT_ONE;
        end
    end

    // Read pointer: init (from the current head) has priority over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_r <= '0;
        end else if (init_circ_buf_rd_addr) begin
            rd_addr_r <= fifo_head_s;
        end else if (inc_circ_buf_rd_addr) begin
            rd_addr_r <= rd_addr_r + ADDR_ONE;
        end
    end

    cbuf_trig_fifo #(
        .W  (ADDR_W),
        .AW (FIFO_AW)
    ) u_trig_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (arm_entry_s),
        .push      (accept_s),
        .push_data (push_addr_s),
        .pop       (trig_addr_rd_en),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    assign cbuf_wr_addr    = wr_addr_r;
    assign cbuf_rd_addr    = rd_addr_r;
    assign trig_addr       = fifo_head_s;
    assign trig_fifo_empty = fifo_empty_s;
    assign trig_fifo_full  = fifo_full_s;
    assign trig_drop_cnt   = drop_cnt_r;
    assign cbuf_ready      = ready_r;

endmodule : cbuf_addr_ctrl

// File: tb/tb_cbuf_addr_ctrl.sv
// Self-checking bench for cbuf_addr_ctrl: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_cbuf_addr_ctrl;

    localparam int AW    = 12;
    localparam int AMASK = 4095;
    localparam int FDEP  = 8;
    localparam int PH_OFF = 0, PH_WARM = 1, PH_READY = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cbuf_wr_en, acq_armed, trig_pulse, trig_addr_rd_en;
    logic          init_circ_buf_rd_addr, inc_circ_buf_rd_addr;
    logic [AW-1:0] pretrig_len;
    logic [AW-1:0] cbuf_wr_addr, cbuf_rd_addr, trig_addr;
    logic          trig_fifo_empty, trig_fifo_full, cbuf_ready;
    logic [7:0]    trig_drop_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_wr, m_rd, m_fill, m_drop, m_phase, m_stale;
    int m_q[$];

    always #5 clk = ~clk;

    cbuf_addr_ctrl dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .cbuf_wr_en            (cbuf_wr_en),
        .acq_armed             (acq_armed),
        .trig_pulse            (trig_pulse),
        .pretrig_len           (pretrig_len),
        .trig_addr_rd_en       (trig_addr_rd_en),
        .init_circ_buf_rd_addr (init_circ_buf_rd_addr),
        .inc_circ_buf_rd_addr  (inc_circ_buf_rd_addr),
        .cbuf_wr_addr          (cbuf_wr_addr),
        .cbuf_rd_addr          (cbuf_rd_addr),
        .trig_addr             (trig_addr),
        .trig_fifo_empty       (trig_fifo_empty),
        .trig_fifo_full        (trig_fifo_full),
        .trig_drop_cnt         (trig_drop_cnt),
        .cbuf_ready            (cbuf_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_fill = 0; m_drop = 0; m_phase = PH_OFF; m_stale = 0;
        m_q.delete();
    endtask

    // One clock of the behavioural model, using the inputs held during this edge.
    task automatic model_step();
        int  head, pushval, nphase, popped;
        bit  entering, accept, drop;
        head     = (m_q.size() > 0) ? m_q[0] : m_stale;
        pushval  = (m_wr - int'(pretrig_len)) & AMASK;
        entering = (m_phase == PH_OFF) && acq_armed;
        accept   = trig_pulse && (m_phase == PH_READY) && ((m_q.size() < FDEP) || trig_addr_rd_en);
        drop     = trig_pulse && ((m_phase == PH_WARM) || ((m_phase == PH_READY) && !accept));
        if (!acq_armed)                                         nphase = PH_OFF;
        else if (m_phase == PH_OFF)                             nphase = PH_WARM;
        else if (m_phase == PH_WARM && m_fill >= int'(pretrig_len)) nphase = PH_READY;
        else                                                    nphase = m_phase;
        if (init_circ_buf_rd_addr)      m_rd = head;
        else if (inc_circ_buf_rd_addr)  m_rd = (m_rd + 1) & AMASK;
        if (entering) begin
            m_stale = head;
            m_q.delete();
            m_drop = 0;
            m_fill = 0;
        end else begin
            if (trig_addr_rd_en && m_q.size() > 0) begin
                popped  = m_q.pop_front();
                m_stale = popped;
            end
            if (accept) m_q.push_back(pushval);
            if (drop && m_drop < 255) m_drop++;
            if (m_phase == PH_WARM && cbuf_wr_en && m_fill < AMASK) m_fill++;
        end
        if (cbuf_wr_en) m_wr = (m_wr + 1) & AMASK;
        m_phase = nphase;
    endtask

    task automatic compare_all();
        chk("wr_addr", 32'(cbuf_wr_addr), m_wr);
        chk("rd_addr", 32'(cbuf_rd_addr), m_rd);
        chk("trig_addr", 32'(trig_addr), (m_q.size() > 0) ? m_q[0] : m_stale);
        chk("empty", 32'(trig_fifo_empty), (m_q.size() == 0) ? 1 : 0);
        chk("full", 32'(trig_fifo_full), (m_q.size() == FDEP) ? 1 : 0);
        chk("drop_cnt", 32'(trig_drop_cnt), m_drop);
        chk("ready", 32'(cbuf_ready), (m_phase == PH_READY) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_wr"},    32'(cbuf_wr_addr), 0);
        chk({tag, "_rd"},    32'(cbuf_rd_addr), 0);
        chk({tag, "_head"},  32'(trig_addr), 0);
        chk({tag, "_empty"}, 32'(trig_fifo_empty), 1);
        chk({tag, "_full"},  32'(trig_fifo_full), 0);
        chk({tag, "_drop"},  32'(trig_drop_cnt), 0);
        chk({tag, "_ready"}, 32'(cbuf_ready), 0);
    endtask

    task automatic run_until_wr(input int target, input int limit);
        int n;
        n = 0;
        while (m_wr != target && n < limit) begin
            tick();
            n++;
        end
        chk("wait_wr_addr", 32'(cbuf_wr_addr), target);
    endtask

    task automatic idle_inputs();
        cbuf_wr_en = 1'b0; acq_armed = 1'b0; trig_pulse = 1'b0; trig_addr_rd_en = 1'b0;
        init_circ_buf_rd_addr = 1'b0; inc_circ_buf_rd_addr = 1'b0;
    endtask

    initial begin
        int n, tail_exp, exp_addr;
        idle_inputs();
        pretrig_len = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        model_reset();
        reset_n = 1'b1;

        // Main path: arm with 256 pre-trigger words, trigger at write address 300.
        pretrig_len = 12'd256;
        cbuf_wr_en  = 1'b1;
        acq_armed   = 1'b1;
        run_until_wr(300, 400);
        chk("ready_before_trig", 32'(cbuf_ready), 1);
        trig_pulse = 1'b1; tick(); trig_pulse = 1'b0;
        chk("tp_head_44", 32'(trig_addr), 44);
        chk("tp_not_empty", 32'(trig_fifo_empty), 0);

        // Readout: init and pop together, then four increments.
        init_circ_buf_rd_addr = 1'b1; trig_addr_rd_en = 1'b1; tick();
        init_circ_buf_rd_addr = 1'b0; trig_addr_rd_en = 1'b0;
        chk("rd_init_44", 32'(cbuf_rd_addr), 44);
        chk("pop_to_empty", 32'(trig_fifo_empty), 1);
        inc_circ_buf_rd_addr = 1'b1; repeat (4) tick(); inc_circ_buf_rd_addr = 1'b0;
        chk("rd_inc_48", 32'(cbuf_rd_addr), 48);

        // Wrap of the pre-trigger subtraction.
        run_until_wr(100, 4200);
        trig_pulse = 1'b1; tick(); trig_pulse = 1'b0;
        chk("wrap_head_3940", 32'(trig_addr), 3940);

        // Read pointer wrap from 4095 to 0.
        init_circ_buf_rd_addr = 1'b1; tick(); init_circ_buf_rd_addr = 1'b0;
        chk("rd_init_3940", 32'(cbuf_rd_addr), 3940);
        inc_circ_buf_rd_addr = 1'b1;
        n = 0;
        while (m_rd != 4095 && n < 300) begin tick(); n++; end
        chk("rd_4095", 32'(cbuf_rd_addr), 4095);
        tick(); inc_circ_buf_rd_addr = 1'b0;
        chk("rd_wrap_0", 32'(cbuf_rd_addr), 0);

        // Warm-up: trigger after 100 writes is dropped; flush on re-arm.
        acq_armed = 1'b0; tick();
        acq_armed = 1'b1; tick();
        chk("rearm_flush_empty", 32'(trig_fifo_empty), 1);
        chk("rearm_not_ready", 32'(cbuf_ready), 0);
        repeat (100) tick();
        trig_pulse = 1'b1; tick(); trig_pulse = 1'b0;
        chk("warm_drop_1", 32'(trig_drop_cnt), 1);
        chk("warm_no_push", 32'(trig_fifo_empty), 1);
        n = 0;
        while (m_phase != PH_READY && n < 300) begin tick(); n++; end
        chk("warm_ready", 32'(cbuf_ready), 1);
        exp_addr = (m_wr - 256) & AMASK;
        trig_pulse = 1'b1; tick(); trig_pulse = 1'b0;
        chk("warm_push_ok", 32'(trig_fifo_empty), 0);
        chk("warm_push_addr", 32'(trig_addr), exp_addr);

        // Full FIFO with pretrig_len = 0 (READY on first WARMUP cycle).
        acq_armed = 1'b0; tick();
        pretrig_len = 12'd0;
        acq_armed = 1'b1; tick(); tick();
        chk("len0_ready", 32'(cbuf_ready), 1);
        trig_pulse = 1'b1; repeat (9) tick(); trig_pulse = 1'b0;
        chk("full_flag", 32'(trig_fifo_full), 1);
        chk("full_drop_1", 32'(trig_drop_cnt), 1);
        tail_exp = m_wr;
        trig_pulse = 1'b1; trig_addr_rd_en = 1'b1; tick();
        trig_pulse = 1'b0; trig_addr_rd_en = 1'b0;
        chk("full_pushpop_full", 32'(trig_fifo_full), 1);
        chk("full_pushpop_nodrop", 32'(trig_drop_cnt), 1);
        trig_addr_rd_en = 1'b1; repeat (7) tick(); trig_addr_rd_en = 1'b0;
        chk("tail_value", 32'(trig_addr), tail_exp);
        chk("tail_not_empty", 32'(trig_fifo_empty), 0);

        // Reset mid-operation: 3 entries queued, read pointer at 500.
        trig_pulse = 1'b1; repeat (2) tick(); trig_pulse = 1'b0;
        init_circ_buf_rd_addr = 1'b1; tick(); init_circ_buf_rd_addr = 1'b0;
        inc_circ_buf_rd_addr = 1'b1;
        n = 0;
        while (m_rd != 500 && n < 4200) begin tick(); n++; end
        inc_circ_buf_rd_addr = 1'b0;
        chk("pre_reset_rd_500", 32'(cbuf_rd_addr), 500);
        chk("pre_reset_3_entries", 32'(m_q.size()), 3);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        idle_inputs();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic against the model.
        pretrig_len = 12'(5);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 149) == 0) acq_armed = ~acq_armed;
            else if (i == 0) acq_armed = 1'b1;
            if (!acq_armed) pretrig_len = 12'($urandom_range(0, 40));
            cbuf_wr_en            = ($urandom_range(0, 3) != 0);
            trig_pulse            = ($urandom_range(0, 5) == 0);
            trig_addr_rd_en       = ($urandom_range(0, 6) == 0);
            init_circ_buf_rd_addr = ($urandom_range(0, 9) == 0);
            inc_circ_buf_rd_addr  = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cbuf_addr_ctrl
